// File: rtl/fifo_sync_prog.sv
// Synchronous first-word-fall-through FIFO with programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. Storage is never cleared; only pointers and level reset.
module fifo_sync_prog #(
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned Depth          = 16,
    parameter int unsigned AlmostFullThr  = Depth - 2,
    parameter int unsigned AlmostEmptyThr = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       rready_i,
    output logic                       rvalid_o,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth+1)-1:0] level_o,
    output logic                       is_full_o,
    output logic                       is_empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned LvlW = $clog2(Depth + 1);

    if (DataWidth < 1) begin : g_err_width
        $error("fifo_sync_prog: DataWidth must be >= 1");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_err_depth
        $error("fifo_sync_prog: Depth must be a power of two >= 2");
    end
    if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_err_afull
        $error("fifo_sync_prog: AlmostFullThr must be in 1..Depth");
    end
    if (AlmostEmptyThr > Depth - 1) begin : g_err_aempty
        $error("fifo_sync_prog: AlmostEmptyThr must be in 0..Depth-1");
    end

    logic [DataWidth-1:0] r_mem [Depth];
    logic [PtrW-1:0]      r_wptr;
    logic [PtrW-1:0]      r_rptr;
    logic [LvlW-1:0]      r_level;
    logic                 r_overflow;
    logic                 r_underflow;

    logic w_wr_en;
    logic w_rd_en;

    always_comb begin
        wready_o = (r_level < LvlW'(Depth)) & ~reset_i & ~flush_i;
        rvalid_o = (r_level != '0);
        data_o   = r_mem[r_rptr];
        // Reads in a reset/flush cycle are not consumed even though rvalid_o may be high.
        w_wr_en  = wvalid_i & wready_o;
        w_rd_en  = rready_i & rvalid_o & ~reset_i & ~flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + LvlW'(1);
                2'b01:   r_level <= r_level - LvlW'(1);
                default: r_level <= r_level;
            endcase
            if (wvalid_i && !wready_o) begin
                r_overflow <= 1'b1;
            end
            if (rready_i && !rvalid_o) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        level_o        = r_level;
        is_full_o      = (r_level == LvlW'(Depth));
        is_empty_o     = (r_level == '0);
        almost_full_o  = (r_level >= LvlW'(AlmostFullThr));
        almost_empty_o = (r_level <= LvlW'(AlmostEmptyThr));
        overflow_o     = r_overflow;
        underflow_o    = r_underflow;
    end

endmodule
